matrix_operand_loader: RTL and testbench

- Upstream feeder for the 3x3 minifloat matrix-multiply engine.
- Accepts a serial byte stream of 18 minifloat elements through a valid/ready handshake: matrix A row-major, then matrix B row-major.
- Presents the elements on the engine's 18 parallel operand ports, then sequences the engine's reset and start controls for a fixed run window.
- Signals result availability to the consumer and waits for acknowledgement before loading the next matrix pair.

---
 rtl/matrix_operand_loader_pkg.sv | 25 ++
 rtl/matrix_operand_loader.sv | 137 +++++++++++++
 tb/tb_matrix_operand_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_operand_loader_pkg.sv
// rtl/matrix_operand_loader_pkg.sv - shared states and constants for the matrix operand loader
package matrix_operand_loader_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_ELEMS = 18;
    localparam int MAT_ELEMS = 9;
    localparam int MAT_DIM   = 3;

    // Minifloat layout: sign[7], exponent[6:4] with bias 3, mantissa[3:0]
    localparam int SIGN_BIT = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 4;
    localparam int MAN_MSB  = 3;
    localparam int EXP_BIAS = 3;

    localparam logic [7:0] MF_ONE = 8'h30;
    localparam logic [7:0] MF_TWO = 8'h40;

endpackage

// File: rtl/matrix_operand_loader.sv
// rtl/matrix_operand_loader.sv - serial-to-parallel operand feeder and run sequencer for the 3x3 matmul engine
module matrix_operand_loader
    import matrix_operand_loader_pkg::*;
#(
    parameter int DW         = 8,
    parameter int PW         = 9,
    parameter int RUN_CYCLES = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [PW-1:0] a00,
    output logic [PW-1:0] a01,
    output logic [PW-1:0] a02,
    output logic [PW-1:0] a10,
    output logic [PW-1:0] a11,
    output logic [PW-1:0] a12,
    output logic [PW-1:0] a20,
    output logic [PW-1:0] a21,
    output logic [PW-1:0] a22,
    output logic [PW-1:0] b00,
    output logic [PW-1:0] b01,
    output logic [PW-1:0] b02,
    output logic [PW-1:0] b10,
    output logic [PW-1:0] b11,
    output logic [PW-1:0] b12,
    output logic [PW-1:0] b20,
    output logic [PW-1:0] b21,
    output logic [PW-1:0] b22,
    output logic          mm_reset,
    output logic          mm_start,
    output logic          result_valid,
    input  logic          result_ack,
    output logic          busy
);

    localparam int RW = $clog2(RUN_CYCLES + 1);

    state_t        r_state;
    logic [4:0]    r_elem_cnt;
    logic [RW-1:0] r_run_cnt;
    logic [DW-1:0] r_a [MAT_ELEMS];
    logic [DW-1:0] r_b [MAT_ELEMS];
    logic          r_mm_start;
    logic          r_result_valid;
    logic          r_busy;
    logic          w_beat;

    // The engine must also be cleared whenever this loader is reset
    assign mm_reset     = reset | (r_state == CLEAR);
    assign in_ready     = (r_state == LOAD) & ~reset;
    assign w_beat       = in_valid & in_ready;
    assign mm_start     = r_mm_start;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= LOAD;
            r_elem_cnt     <= '0;
            r_run_cnt      <= '0;
            r_mm_start     <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            for (int i = 0; i < MAT_ELEMS; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_beat) begin
                        // Beat index is the row-major slot: A first, then B
                        for (int i = 0; i < MAT_ELEMS; i++) begin
                            if (r_elem_cnt == 5'(i))
                                r_a[i] <= in_data;
                            if (r_elem_cnt == 5'(i + MAT_ELEMS))
                                r_b[i] <= in_data;
                        end
                        if (r_elem_cnt == 5'(NUM_ELEMS - 1)) begin
                            r_elem_cnt <= '0;
                            r_state    <= CLEAR;
                            r_busy     <= 1'b1;
                        end else begin
                            r_elem_cnt <= r_elem_cnt + 5'd1;
                        end
                    end
                end
                CLEAR: begin
                    r_state    <= RUN;
                    r_run_cnt  <= '0;
                    r_mm_start <= 1'b1;
                end
                RUN: begin
                    if (r_run_cnt == RW'(RUN_CYCLES - 1)) begin
                        r_run_cnt      <= '0;
                        r_state        <= DONE;
                        r_mm_start     <= 1'b0;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        r_state        <= LOAD;
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign a00 = PW'(r_a[0]);
    assign a01 = PW'(r_a[1]);
    assign a02 = PW'(r_a[2]);
    assign a10 = PW'(r_a[3]);
    assign a11 = PW'(r_a[4]);
    assign a12 = PW'(r_a[5]);
    assign a20 = PW'(r_a[6]);
    assign a21 = PW'(r_a[7]);
    assign a22 = PW'(r_a[8]);
    assign b00 = PW'(r_b[0]);
    assign b01 = PW'(r_b[1]);
    assign b02 = PW'(r_b[2]);
    assign b10 = PW'(r_b[3]);
    assign b11 = PW'(r_b[4]);
    assign b12 = PW'(r_b[5]);
    assign b20 = PW'(r_b[6]);
    assign b21 = PW'(r_b[7]);
    assign b22 = PW'(r_b[8]);

endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb/tb_matrix_operand_loader.sv - self-checking bench for matrix_operand_loader
module tb_matrix_operand_loader;
    import matrix_operand_loader_pkg::*;

    localparam int DW = 8;
    localparam int PW = 9;
    localparam int RC = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          result_ack;
    logic          in_ready, mm_reset, mm_start, result_valid, busy;
    logic [PW-1:0] a_w [9];
    logic [PW-1:0] b_w [9];

    int total = 0;
    int bad   = 0;

    // Reference model: next element index and expected contents of both matrices
    int            mk;
    logic [DW-1:0] ma [9];
    logic [DW-1:0] mb [9];
    logic [DW-1:0] stim [18];

    matrix_operand_loader #(.DW(DW), .PW(PW), .RUN_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .a00(a_w[0]), .a01(a_w[1]), .a02(a_w[2]), .a10(a_w[3]), .a11(a_w[4]),
        .a12(a_w[5]), .a20(a_w[6]), .a21(a_w[7]), .a22(a_w[8]),
        .b00(b_w[0]), .b01(b_w[1]), .b02(b_w[2]), .b10(b_w[3]), .b11(b_w[4]),
        .b12(b_w[5]), .b20(b_w[6]), .b21(b_w[7]), .b22(b_w[8]),
        .mm_reset(mm_reset), .mm_start(mm_start), .result_valid(result_valid),
        .result_ack(result_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mk = 0;
        for (int i = 0; i < 9; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
    endtask

    task automatic model_accept(input logic [DW-1:0] d);
        if (mk < 9) ma[mk] = d;
        else        mb[mk - 9] = d;
        mk = (mk + 1) % 18;
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_wait in_ready=%b want 1", in_ready);
        end else begin
            step();
            model_accept(d);
        end
        in_valid = 1'b0;
    endtask

    task automatic load_all(input bit gapped);
        do begin
            if (gapped) step();
            send_beat(stim[mk]);
        end while (mk != 0);
    endtask

    task automatic randomize_stim();
        for (int i = 0; i < 18; i++) stim[i] = DW'($urandom_range(0, 255));
    endtask

    // Entered in the CLEAR cycle right after the last beat; returns in the first LOAD cycle
    task automatic run_window(input bit ack_pre, input int ack_delay, input bit hold_ff);
        result_ack = ack_pre;
        if (hold_ff) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
        end
        total++;
        if ({mm_reset, mm_start, result_valid, busy, in_ready} !== 5'b10010) begin
            bad++;
            $display("FAIL clear_cycle rst/start/rv/busy/rdy=%b want 10010",
                     {mm_reset, mm_start, result_valid, busy, in_ready});
        end
        for (int j = 2; j <= RC + 1; j++) begin
            step();
            total++;
            if ({mm_reset, mm_start, result_valid, in_ready} !== 4'b0100) begin
                bad++;
                $display("FAIL run_cycle%0d rst/start/rv/rdy=%b want 0100", j,
                         {mm_reset, mm_start, result_valid, in_ready});
            end
        end
        if (ack_pre) begin
            step();
            total++;
            if ({result_valid, mm_start} !== 2'b10) begin
                bad++;
                $display("FAIL done_pre_ack rv/start=%b want 10", {result_valid, mm_start});
            end
        end else begin
            for (int d = 0; d < ack_delay; d++) begin
                step();
                total++;
                if ({result_valid, mm_start, busy, in_ready} !== 4'b1010) begin
                    bad++;
                    $display("FAIL done_cycle%0d rv/start/busy/rdy=%b want 1010", d,
                             {result_valid, mm_start, busy, in_ready});
                end
                if (d == ack_delay - 1) result_ack = 1'b1;
            end
        end
        step();
        result_ack = 1'b0;
        total++;
        if ({result_valid, mm_start, busy, in_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL back_to_load rv/start/busy/rdy=%b want 0001",
                     {result_valid, mm_start, busy, in_ready});
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (a_w[i] !== PW'(ma[i]) || b_w[i] !== PW'(mb[i])) begin
                bad++;
                $display("FAIL operand_hold%0d a=%h b=%h want %h %h", i, a_w[i], b_w[i], ma[i], mb[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; result_ack = 1'b0;
        step();
        step();
        model_clear();
        total++;
        if ({mm_reset, in_ready} !== 2'b10) begin
            bad++;
            $display("FAIL reset_active mm_reset/in_ready=%b want 10", {mm_reset, in_ready});
        end
        reset = 1'b0;
        #1;
        total++;
        if ({mm_reset, mm_start, result_valid, busy, in_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_values rst/start/rv/busy/rdy=%b want 00001",
                     {mm_reset, mm_start, result_valid, busy, in_ready});
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (a_w[i] !== '0 || b_w[i] !== '0) begin
                bad++;
                $display("FAIL reset_operand%0d a=%h b=%h want 0", i, a_w[i], b_w[i]);
            end
        end
    endtask

    task automatic test_mapping();
        for (int i = 0; i < 18; i++) stim[i] = DW'(i + 1);
        load_all(1'b0);
        total++;
        if ({a_w[0], a_w[1], a_w[8], b_w[0], b_w[5], b_w[8]} !==
            {9'h001, 9'h002, 9'h009, 9'h00A, 9'h00F, 9'h012}) begin
            bad++;
            $display("FAIL mapping a00=%h a01=%h a22=%h b00=%h b12=%h b22=%h",
                     a_w[0], a_w[1], a_w[8], b_w[0], b_w[5], b_w[8]);
        end
        run_window(1'b0, 1, 1'b0);
    endtask

    task automatic test_gapped_identity();
        for (int i = 0; i < 9; i++) begin
            stim[i]     = (i % 4 == 0) ? MF_ONE : 8'h00;
            stim[i + 9] = MF_TWO;
        end
        load_all(1'b1);
        run_window(1'b0, 5, 1'b0);
    endtask

    task automatic test_backpressure();
        randomize_stim();
        load_all(1'b0);
        run_window(1'b1, 0, 1'b1);
        step();
        model_accept(8'hFF);
        in_valid = 1'b0;
        total++;
        if (a_w[0] !== 9'h0FF) begin
            bad++;
            $display("FAIL bp_first_beat a00=%h want 0ff", a_w[0]);
        end
        randomize_stim();
        load_all(1'b0);
        run_window(1'b0, 2, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        randomize_stim();
        load_all(1'b0);
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        total++;
        if ({mm_reset, mm_start, in_ready} !== 3'b110) begin
            bad++;
            $display("FAIL midrun_reset_cycle rst/start/rdy=%b want 110", {mm_reset, mm_start, in_ready});
        end
        step();
        reset = 1'b0;
        model_clear();
        #1;
        total++;
        if ({mm_reset, mm_start, result_valid, busy, in_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL midrun_after rst/start/rv/busy/rdy=%b want 00001",
                     {mm_reset, mm_start, result_valid, busy, in_ready});
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (a_w[i] !== '0 || b_w[i] !== '0) begin
                bad++;
                $display("FAIL midrun_operand%0d a=%h b=%h want 0", i, a_w[i], b_w[i]);
            end
        end
    endtask

    task automatic test_reset_partial_load();
        randomize_stim();
        for (int i = 0; i < 5; i++) send_beat(stim[i]);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
        randomize_stim();
        load_all(1'b1);
        run_window(1'b0, 3, 1'b0);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_mapping();
        test_gapped_identity();
        test_backpressure();
        test_reset_mid_run();
        test_reset_partial_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
